// File: rtl/jam_pkg.sv
// Shared types and constants for the exhaustive job-assignment solver.
package jam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } jam_state_e;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/jam_perm_next.sv
// Combinational next-lexicographic-permutation generator.
// The order vector is packed: element i lives in order[i*IW +: IW].
// is_last is raised when the input is fully descending (no successor).
module jam_perm_next #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N*IW-1:0] order,
    output logic [N*IW-1:0] next_order,
    output logic            is_last
);

    logic [IW-1:0] a [N];
    logic [IW-1:0] b [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign a[gi] = order[gi*IW +: IW];
        end
    endgenerate

    // Pivot search, swap with smallest larger suffix element, then reverse the suffix.
    always_comb begin
        int   pivot;
        int   pv;
        int   sw;
        logic found;
        pivot = 0;
        pv    = 0;
        sw    = 0;
        found = 1'b0;
        // Rightmost ascent a[i-1] < a[i]; later hits overwrite earlier ones.
        for (int i = 1; i < N; i++) begin
            if (a[IW'(i-1)] < a[IW'(i)]) begin
                pivot = i;
                found = 1'b1;
            end
        end
        pv = found ? pivot - 1 : 0;
        // Suffix is descending, so the rightmost larger element is the smallest larger one.
        for (int j = 1; j < N; j++) begin
            if (found && (j >= pivot) && (a[IW'(j)] > a[IW'(pv)])) begin
                sw = j;
            end
        end
        for (int k = 0; k < N; k++) begin
            b[k] = a[k];
        end
        b[IW'(pv)] = a[IW'(sw)];
        b[IW'(sw)] = a[IW'(pv)];
        next_order = '0;
        for (int k = 0; k < N; k++) begin
            if (found && (k >= pivot)) begin
                next_order[k*IW +: IW] = b[IW'(N - 1 + pivot - k)];
            end else begin
                next_order[k*IW +: IW] = b[IW'(k)];
            end
        end
        is_last = ~found;
    end

endmodule

// File: rtl/jam_assign_param.sv
// Exhaustive NxN job-assignment solver: loads a cost matrix from an external
// ROM, walks every permutation in lexicographic order and keeps the best
// total cost (min or max) together with the number of assignments hitting it.
module jam_assign_param
    import jam_pkg::*;
#(
    parameter int N   = 8,
    parameter int CW  = 7,
    parameter int MCW = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int SW = CW + $clog2(N) + 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic           mode,
    output logic [IW-1:0]  W,
    output logic [IW-1:0]  J,
    input  logic [CW-1:0]  Cost,
    output logic           busy,
    output logic           Valid,
    output logic [SW-1:0]  BestCost,
    output logic [MCW-1:0] MatchCount
);

    function automatic logic [N*IW-1:0] identity_order();
        logic [N*IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*IW +: IW] = IW'(i);
        end
        return r;
    endfunction

    localparam logic [N*IW-1:0] IDENT = identity_order();

    jam_state_e      state_reg, state_next;
    logic [CW-1:0]   cost_reg [N][N];
    logic [N*IW-1:0] order_reg;
    logic [N*IW-1:0] next_order;
    logic            is_last;
    logic            mode_reg;
    logic            first_reg;
    logic [IW-1:0]   w_reg, j_reg;
    logic [SW-1:0]   best_reg;
    logic [MCW-1:0]  count_reg;
    logic [SW-1:0]   sum;
    logic            start_ok;
    logic            load_last;
    logic            better;
    logic            equal;

    assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign load_last = (w_reg == IW'(N-1)) && (j_reg == IW'(N-1));

    jam_perm_next #(.N(N), .IW(IW)) u_perm (
        .order      (order_reg),
        .next_order (next_order),
        .is_last    (is_last)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)     state_next = LOAD;
            LOAD:    if (load_last) state_next = EVAL;
            EVAL:    if (is_last)   state_next = DONE;
            DONE:    if (start)     state_next = LOAD;
            default:                state_next = IDLE;
        endcase
    end

    // Row-major walk of the cost ROM address during LOAD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_reg <= '0;
            j_reg <= '0;
        end else if (start_ok) begin
            w_reg <= '0;
            j_reg <= '0;
        end else if (state_reg == LOAD) begin
            if (j_reg == IW'(N-1)) begin
                j_reg <= '0;
                w_reg <= load_last ? '0 : w_reg + IW'(1);
            end else begin
                j_reg <= j_reg + IW'(1);
            end
        end
    end

    // Cost regfile: one entry captured per LOAD cycle at its own (W,J).
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                // Capture ROM output when the walk reaches this entry.
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        cost_reg[gi][gj] <= '0;
                    end else if ((state_reg == LOAD) && (w_reg == IW'(gi)) && (j_reg == IW'(gj))) begin
                        cost_reg[gi][gj] <= Cost;
                    end
                end
            end
        end
    endgenerate

    // Total cost of the current permutation.
    always_comb begin
        sum = '0;
        for (int w = 0; w < N; w++) begin
            sum = sum + SW'(cost_reg[IW'(w)][order_reg[w*IW +: IW]]);
        end
    end

    assign better = (mode_reg == MODE_MAX) ? (sum > best_reg) : (sum < best_reg);
    assign equal  = (sum == best_reg);

    // Permutation stepping and best/count tracking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            order_reg <= IDENT;
            mode_reg  <= 1'b0;
            first_reg <= 1'b0;
            best_reg  <= '0;
            count_reg <= '0;
        end else if (start_ok) begin
            order_reg <= IDENT;
            mode_reg  <= mode;
            first_reg <= 1'b1;
        end else if (state_reg == EVAL) begin
            order_reg <= next_order;
            first_reg <= 1'b0;
            if (first_reg || better) begin
                best_reg  <= sum;
                count_reg <= MCW'(1);
            end else if (equal && (count_reg != '1)) begin
                count_reg <= count_reg + MCW'(1);
            end
        end
    end

    assign W          = w_reg;
    assign J          = j_reg;
    assign busy       = (state_reg == LOAD) || (state_reg == EVAL);
    assign Valid      = (state_reg == DONE);
    assign BestCost   = best_reg;
    assign MatchCount = count_reg;

endmodule

// File: tb/tb_jam_assign_param.sv
// Bench for jam_assign_param: three instances (N=8, N=3, N=5) each fed by a
// bench-side cost ROM; runs a table of vectors plus reset/restart sequences.
module tb_jam_assign_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;
    logic start_a [3];
    logic mode_a  [3];
    logic busy_a  [3];
    logic valid_a [3];
    int   best_a  [3];
    int   cnt_a   [3];
    int   w_a     [3];
    int   j_a     [3];
    int   rom [3][8][8];
    int   nsz [3] = '{8, 3, 5};

    int n_cmp = 0;
    int n_bad = 0;

    // N=8 instance
    logic [2:0]  w8, j8;
    logic [6:0]  cost8;
    logic        busy8, valid8;
    logic [10:0] best8;
    logic [15:0] cnt8;
    assign cost8 = 7'(rom[0][w8][j8]);
    jam_assign_param #(.N(8), .CW(7), .MCW(16)) u8 (
        .CLK(CLK), .RST(RST), .start(start_a[0]), .mode(mode_a[0]),
        .W(w8), .J(j8), .Cost(cost8), .busy(busy8), .Valid(valid8),
        .BestCost(best8), .MatchCount(cnt8));

    // N=3 instance
    logic [1:0]  w3, j3;
    logic [6:0]  cost3;
    logic        busy3, valid3;
    logic [9:0]  best3;
    logic [15:0] cnt3;
    assign cost3 = 7'(rom[1][w3][j3]);
    jam_assign_param #(.N(3), .CW(7), .MCW(16)) u3 (
        .CLK(CLK), .RST(RST), .start(start_a[1]), .mode(mode_a[1]),
        .W(w3), .J(j3), .Cost(cost3), .busy(busy3), .Valid(valid3),
        .BestCost(best3), .MatchCount(cnt3));

    // N=5 instance
    logic [2:0]  w5, j5;
    logic [6:0]  cost5;
    logic        busy5, valid5;
    logic [10:0] best5;
    logic [15:0] cnt5;
    assign cost5 = 7'(rom[2][w5][j5]);
    jam_assign_param #(.N(5), .CW(7), .MCW(16)) u5 (
        .CLK(CLK), .RST(RST), .start(start_a[2]), .mode(mode_a[2]),
        .W(w5), .J(j5), .Cost(cost5), .busy(busy5), .Valid(valid5),
        .BestCost(best5), .MatchCount(cnt5));

    assign busy_a[0] = busy8;  assign valid_a[0] = valid8;
    assign busy_a[1] = busy3;  assign valid_a[1] = valid3;
    assign busy_a[2] = busy5;  assign valid_a[2] = valid5;
    assign best_a[0] = int'(best8); assign cnt_a[0] = int'(cnt8);
    assign best_a[1] = int'(best3); assign cnt_a[1] = int'(cnt3);
    assign best_a[2] = int'(best5); assign cnt_a[2] = int'(cnt5);
    assign w_a[0] = int'(w8); assign j_a[0] = int'(j8);
    assign w_a[1] = int'(w3); assign j_a[1] = int'(j3);
    assign w_a[2] = int'(w5); assign j_a[2] = int'(j5);

    // pat: 0 diag(0/10), 1 (w+1)*(j+1), 2 all 5, 3 w+j, 4 random
    typedef struct {
        int k;
        int m;
        int pat;
        int exp_best;   // -1: take from brute-force model
        int exp_cnt;
        int poke;       // cycle at which to pulse start during the run (0 = none)
    } vec_t;

    typedef struct {
        int best;
        int cnt;
    } sb_t;

    sb_t sbq [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void fill(input int k, input int pat);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                case (pat)
                    0:       rom[k][w][j] = (w == j) ? 0 : 10;
                    1:       rom[k][w][j] = (w + 1) * (j + 1);
                    2:       rom[k][w][j] = 5;
                    3:       rom[k][w][j] = w + j;
                    default: rom[k][w][j] = int'($urandom_range(0, 127));
                endcase
            end
        end
    endfunction

    function automatic int fact(input int n);
        int r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    function automatic int psum(input int k, input int n, input int a [8]);
        int s = 0;
        for (int p = 0; p < n; p++) s = s + rom[k][p][a[p]];
        return s;
    endfunction

    // Brute-force reference using Heap's enumeration (order-independent result).
    function automatic sb_t brute(input int k, input int m);
        int   n;
        int   a [8];
        int   c [8];
        int   i, s, t;
        sb_t  r;
        n = nsz[k];
        for (int p = 0; p < 8; p++) begin a[p] = p; c[p] = 0; end
        r.best = psum(k, n, a);
        r.cnt  = 1;
        i = 0;
        while (i < n) begin
            if (c[i] < i) begin
                if (i % 2 == 0) begin t = a[0]; a[0] = a[i]; a[i] = t; end
                else begin t = a[c[i]]; a[c[i]] = a[i]; a[i] = t; end
                s = psum(k, n, a);
                if ((m == 0) ? (s < r.best) : (s > r.best)) begin
                    r.best = s; r.cnt = 1;
                end else if (s == r.best) begin
                    r.cnt++;
                end
                c[i]++;
                i = 0;
            end else begin
                c[i] = 0;
                i++;
            end
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v);
        int  k, n, lat, cyc, wjbad, excl, hb, b0;
        sb_t e, got;
        k = v.k;
        n = nsz[k];
        wjbad = 0; excl = 0; hb = 0;
        fill(k, v.pat);
        if (v.exp_best < 0) e = brute(k, v.m);
        else begin e.best = v.exp_best; e.cnt = v.exp_cnt; end
        sbq.push_back(e);
        lat = 1 + n * n + fact(n);
        @(negedge CLK);
        mode_a[k]  = v.m[0];
        start_a[k] = 1'b1;
        @(negedge CLK);
        start_a[k] = 1'b0;
        cyc = 1;
        while (!valid_a[k] && cyc <= lat + 10) begin
            if (cyc - 1 < n * n) begin
                if (w_a[k] != (cyc - 1) / n || j_a[k] != (cyc - 1) % n) wjbad++;
            end
            if (!busy_a[k]) excl++;
            start_a[k] = (v.poke != 0) && (cyc == v.poke);
            @(negedge CLK);
            cyc++;
        end
        start_a[k] = 1'b0;
        chk("latency", cyc, lat);
        chk("wj_seq_errors", wjbad, 0);
        chk("busy_low_in_run", excl, 0);
        got.best = -1; got.cnt = -1;
        if (sbq.size() > 0) got = sbq.pop_front();
        chk("best_cost", best_a[k], got.best);
        chk("match_count", cnt_a[k], got.cnt);
        b0 = best_a[k];
        repeat (3) begin
            @(negedge CLK);
            if (!valid_a[k] || busy_a[k] || best_a[k] != b0) hb++;
        end
        chk("done_hold_errors", hb, 0);
        $display("run N=%0d mode=%0d pat=%0d poke=%0d best=%0d count=%0d cycles=%0d",
                 n, v.m, v.pat, v.poke, best_a[k], cnt_a[k], cyc);
    endtask

    task automatic rst_check(input int k, input string tag);
        chk({tag, "_busy"},  int'(busy_a[k]), 0);
        chk({tag, "_valid"}, int'(valid_a[k]), 0);
        chk({tag, "_best"},  best_a[k], 0);
        chk({tag, "_count"}, cnt_a[k], 0);
        chk({tag, "_wj"},    w_a[k] + j_a[k], 0);
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{0, 0, 0, 0,  1,   0};
        vecs[1]  = '{1, 0, 1, 10, 1,   0};
        vecs[2]  = '{1, 1, 1, 14, 1,   0};
        vecs[3]  = '{1, 0, 4, -1, -1,  0};
        vecs[4]  = '{1, 1, 4, -1, -1,  0};
        vecs[5]  = '{2, 0, 2, 25, 120, 0};
        vecs[6]  = '{2, 1, 2, 25, 120, 0};
        vecs[7]  = '{2, 0, 3, 20, 120, 0};
        vecs[8]  = '{2, 1, 3, 20, 120, 0};
        vecs[9]  = '{2, 0, 4, -1, -1,  0};
        vecs[10] = '{2, 1, 4, -1, -1,  0};
        vecs[11] = '{2, 0, 3, 20, 120, 60};
        vecs[12] = '{2, 1, 4, -1, -1,  40};

        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0;
            mode_a[k]  = 1'b0;
            fill(k, 2);
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        rst_check(0, "reset8");
        rst_check(1, "reset3");
        rst_check(2, "reset5");
        RST = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset mid-LOAD: asynchronous, so checked before the next clock edge.
        fill(2, 3);
        @(negedge CLK); mode_a[2] = 1'b0; start_a[2] = 1'b1;
        @(negedge CLK); start_a[2] = 1'b0;
        repeat (6) @(negedge CLK);
        RST = 1'b1;
        #1;
        rst_check(2, "rst_mid_load");
        @(negedge CLK); RST = 1'b0;

        // Reset mid-EVAL.
        @(negedge CLK); mode_a[2] = 1'b1; start_a[2] = 1'b1;
        @(negedge CLK); start_a[2] = 1'b0;
        repeat (40) @(negedge CLK);
        RST = 1'b1;
        #1;
        rst_check(2, "rst_mid_eval");
        @(negedge CLK); RST = 1'b0;

        // Fresh run after the aborted ones.
        run_vec(vecs[9]);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
